seq_divider_8_by_4: RTL

SEQ_DIVIDER_8_BY_4 -- requirements
Module: seq_divider_8_by_4

---
 rtl/seq_divider_8_by_4.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_divider_8_by_4.sv
// Sequential restoring divider: 8-bit unsigned dividend by 4-bit unsigned
// divisor, one quotient bit per clock, MSB first. A zero divisor skips the
// iteration and reports quotient 8'hFF, remainder 0 with div_by_zero set.
module seq_divider_8_by_4 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [7:0] quotient,
   output logic [3:0] remainder,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e     state_q, state_d;
   // Dividend bits shift out of the top while quotient bits shift in at the
   // bottom, so after eight steps this register holds the full quotient.
   logic [7:0] shreg_q, shreg_d;
   logic [3:0] dvs_q,   dvs_d;
   logic [2:0] cnt_q,   cnt_d;
   logic [4:0] pr_q,    pr_d;
   logic [7:0] quo_q,   quo_d;
   logic [3:0] rem_q,   rem_d;
   logic       dbz_q,   dbz_d;

   logic [4:0] pr_shift;
   logic [4:0] pr_step;
   logic       q_bit;

   // One restoring step: bring in the next dividend bit, subtract if it fits.
   always_comb begin
      pr_shift = {pr_q[3:0], shreg_q[7]};
      q_bit    = (pr_shift >= {1'b0, dvs_q});
      pr_step  = q_bit ? (pr_shift - {1'b0, dvs_q}) : pr_shift;
   end

   // Next-state and datapath control; every register holds unless told otherwise.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path can infer a latch.
      state_d = state_q;
      shreg_d = shreg_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      pr_d    = pr_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               shreg_d = dividend;
               dvs_d   = divisor;
               cnt_d   = 3'd0;
               pr_d    = 5'd0;
               if (divisor == 4'd0) begin
                  quo_d   = 8'hFF;
                  rem_d   = 4'h0;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            shreg_d = {shreg_q[6:0], q_bit};
            pr_d    = pr_step;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               quo_d   = {shreg_q[6:0], q_bit};
               rem_d   = pr_step[3:0];
               dbz_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shreg_q <= 8'h00;
         dvs_q   <= 4'h0;
         cnt_q   <= 3'd0;
         pr_q    <= 5'd0;
         quo_q   <= 8'h00;
         rem_q   <= 4'h0;
         dbz_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         shreg_q <= shreg_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         pr_q    <= pr_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule
